// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage definitions: reset vector, IF/ID entry layout and fetch states.
// Also a helper that sizes occupancy counters for a given queue depth.
package fetch_queue_pkg;

  localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } IF_ID_Entry;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } FetchState;

  // Counters must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage signal bundle: instruction-memory port, redirect input and IF->ID handshake.
// master = fetch_queue side, slave = memory/ID environment side.
interface fetch_queue_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_adel;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_pc,
    output id_instr,
    output id_adel
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_pc,
    input  id_instr,
    input  id_adel
  );

endinterface

// File: rtl/fetch_fifo.sv
// In-order fetch queue: slots are reserved at wr_ptr, filled at fill_ptr as data
// returns, and popped at rd_ptr. Pre-filled pushes (AdEL entries) advance fill_ptr too.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 push,
  input  IF_ID_Entry           push_entry,
  input  logic                 fill,
  input  logic [31:0]          fill_data,
  input  logic                 pop,
  output IF_ID_Entry           head,
  output logic                 head_filled,
  output logic [$clog2(DEPTH):0] count,
  output logic                 full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  IF_ID_Entry       mem_reg [DEPTH];
  logic [DEPTH-1:0] filled_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] fill_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  logic             do_push;
  logic             do_fill;
  logic             do_pop;
  logic             push_prefilled;
  logic [DEPTH-1:0] slot_push;
  logic [DEPTH-1:0] slot_fill;

  assign do_push        = push && !flush;
  assign do_fill        = fill && !flush;
  assign do_pop         = pop && !flush && (count_reg != '0);
  assign push_prefilled = do_push && push_entry.adel;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_push[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
      assign slot_fill[gi] = do_fill && (fill_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // A slot is never reserved and filled in the same cycle: data trails its request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      filled_reg <= '0;
    end else if (flush) begin
      filled_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_push[i]) begin
          mem_reg[i]    <= push_entry;
          filled_reg[i] <= push_entry.adel;
        end else if (slot_fill[i]) begin
          mem_reg[i].instr <= fill_data;
          filled_reg[i]    <= 1'b1;
        end
      end
    end
  end

  assign count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      fill_ptr_reg <= '0;
      count_reg    <= '0;
    end else if (flush) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      fill_ptr_reg <= '0;
      count_reg    <= '0;
    end else begin
      rd_ptr_reg   <= rd_ptr_reg + PTR_W'(do_pop);
      wr_ptr_reg   <= wr_ptr_reg + PTR_W'(do_push);
      fill_ptr_reg <= fill_ptr_reg + PTR_W'(do_fill) + PTR_W'(push_prefilled);
      count_reg    <= count_next;
    end
  end

  assign head        = mem_reg[rd_ptr_reg];
  assign head_filled = filled_reg[rd_ptr_reg];
  assign count       = count_reg;
  assign full        = (count_reg == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, issues up to DEPTH outstanding fetches and
// hands {pc, instr, adel} to ID in order; redirects flush and discard stale returns.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = PC_RESET_VECTOR
) (
  input  logic          clk,
  input  logic          resetn,
  fetch_queue_if.master bus
);

  localparam int         CNT_W   = cnt_width(DEPTH);
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [31:0]      pc_reg;
  logic [31:0]      pc_next;
  logic [0:0]       state_reg;
  logic [0:0]       state_next;
  logic [CNT_W-1:0] discard_reg;
  logic [CNT_W-1:0] discard_next;
  logic [CNT_W-1:0] inflight_reg;
  logic [CNT_W-1:0] inflight_next;

  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  IF_ID_Entry       head;
  logic             head_filled;
  IF_ID_Entry       push_entry;

  logic can_fetch;
  logic accept;
  logic misalign;
  logic drop_word;
  logic fill_word;
  logic pop;

  // resetn gates the request so it drops the instant reset is asserted.
  assign can_fetch    = resetn && (state_reg == ST_RUN) && !bus.redirect_valid && !fifo_full;
  assign bus.inst_req = can_fetch && (pc_reg[1:0] == 2'b00);
  assign misalign     = can_fetch && (pc_reg[1:0] != 2'b00);
  assign accept       = bus.inst_req && bus.inst_addr_ok;

  assign drop_word = bus.inst_data_ok && (discard_reg != '0);
  assign fill_word = bus.inst_data_ok && (discard_reg == '0) && !bus.redirect_valid;

  assign push_entry = '{pc: pc_reg, instr: 32'h0, adel: misalign};

  assign bus.inst_addr = pc_reg;
  assign bus.id_valid  = head_filled && (fifo_count != '0) && !bus.redirect_valid;
  assign bus.id_pc     = head.pc;
  assign bus.id_instr  = head.adel ? 32'h0 : head.instr;
  assign bus.id_adel   = head.adel;
  assign pop           = bus.id_valid && bus.id_ready;

  // Requests still in flight at a redirect become words to throw away later.
  always_comb begin
    pc_next       = pc_reg;
    state_next    = state_reg;
    discard_next  = discard_reg;
    inflight_next = inflight_reg;
    if (bus.redirect_valid) begin
      pc_next       = bus.redirect_pc;
      state_next    = ST_RUN;
      discard_next  = discard_reg + inflight_reg - CNT_W'(bus.inst_data_ok);
      inflight_next = '0;
    end else begin
      if (accept) begin
        pc_next = pc_reg + 32'd4;
      end
      if (misalign) begin
        state_next = ST_HALT;
      end
      if (drop_word) begin
        discard_next = discard_reg - CNT_W'(1);
      end
      inflight_next = inflight_reg + CNT_W'(accept) - CNT_W'(fill_word);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_reg       <= RESET_PC;
      state_reg    <= ST_RUN;
      discard_reg  <= '0;
      inflight_reg <= '0;
    end else begin
      pc_reg       <= pc_next;
      state_reg    <= state_next;
      discard_reg  <= discard_next;
      inflight_reg <= inflight_next;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (bus.redirect_valid),
    .push        (accept || misalign),
    .push_entry  (push_entry),
    .fill        (fill_word),
    .fill_data   (bus.inst_rdata),
    .pop         (pop),
    .head        (head),
    .head_filled (head_filled),
    .count       (fifo_count),
    .full        (fifo_full)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue: an in-order memory model answers fetches,
// and a program-order reference predicts exactly which {pc, instr, adel} reach ID.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  logic clk;
  logic resetn;
  fetch_queue_if bus();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int cyc      = 0;
  int lat, addr_pct, data_pct, ready_pct;

  mem_req_t    mem_q[$];
  IF_ID_Entry  exp_q[$];
  IF_ID_Entry  mon_e;
  logic [31:0] model_pc;
  bit          model_halt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  // One clock of stimulus; the memory side answers in order with a minimum latency of lat.
  task automatic step(input bit redir, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    cyc++;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    bus.inst_addr_ok   = resetn && ($urandom_range(99) < addr_pct) && (mem_q.size() < DEPTH);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(99) < data_pct) begin
      bus.inst_data_ok = 1'b1;
      bus.inst_rdata   = mem_word(mem_q[0].addr);
    end else begin
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = $urandom;
    end
    bus.id_ready = ($urandom_range(99) < ready_pct);
    @(negedge clk);
    if (!resetn) begin
      mem_q.delete();
    end else begin
      if (bus.inst_data_ok) mem_q.pop_front();
      if (bus.inst_req && bus.inst_addr_ok) mem_q.push_back('{addr: bus.inst_addr, due: cyc + lat});
    end
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) step(1'b0, 32'h0);
    check1("rst_inst_req", bus.inst_req, 1'b0);
    check1("rst_id_valid", bus.id_valid, 1'b0);
    check32("rst_id_pc", bus.id_pc, 32'h0);
    check32("rst_id_instr", bus.id_instr, 32'h0);
    check1("rst_id_adel", bus.id_adel, 1'b0);
    check32("rst_inst_addr", bus.inst_addr, RESET_PC);
    resetn = 1'b1;
  endtask

  // Monitor: pops the expected stream on every ID transfer; tracks the program path.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      model_pc   = RESET_PC;
      model_halt = 1'b0;
    end else begin
      if (bus.id_valid && bus.id_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL id_unexpected: got transfer pc %h, required none", bus.id_pc);
        end else begin
          mon_e = exp_q.pop_front();
          $display("id  pc=%h instr=%h adel=%0d", bus.id_pc, bus.id_instr, bus.id_adel);
          check32("id_pc", bus.id_pc, mon_e.pc);
          check32("id_instr", bus.id_instr, mon_e.instr);
          check1("id_adel", bus.id_adel, mon_e.adel);
        end
      end
      if (bus.redirect_valid) begin
        check1("redirect_id_valid", bus.id_valid, 1'b0);
        check1("redirect_inst_req", bus.inst_req, 1'b0);
        exp_q.delete();
        model_pc   = bus.redirect_pc;
        model_halt = (bus.redirect_pc[1:0] != 2'b00);
        if (model_halt) exp_q.push_back('{pc: bus.redirect_pc, instr: 32'h0, adel: 1'b1});
      end else begin
        if (model_halt) check1("halt_inst_req", bus.inst_req, 1'b0);
        if (bus.inst_req && bus.inst_addr_ok) begin
          check32("inst_addr", bus.inst_addr, model_pc);
          exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc), adel: 1'b0});
          model_pc = model_pc + 32'd4;
          n_acc++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a0;
    logic [31:0] r;
    logic [31:0] tgt;
    resetn             = 1'b0;
    bus.inst_addr_ok   = 1'b0;
    bus.inst_data_ok   = 1'b0;
    bus.inst_rdata     = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;
    lat = 1; addr_pct = 100; data_pct = 100; ready_pct = 100;

    // Streaming from reset: one word per cycle reaches ID from the third cycle on.
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 32'h0);
      if (i >= 3) check1("stream_id_valid", bus.id_valid, 1'b1);
    end

    // ID stalled: queue fills at DEPTH, PC holds, then drains in order.
    do_reset();
    ready_pct = 0;
    a0 = n_acc;
    repeat (10) step(1'b0, 32'h0);
    check32("full_accepts", 32'(n_acc - a0), 32'd4);
    check1("full_inst_req", bus.inst_req, 1'b0);
    check32("full_pc", bus.inst_addr, RESET_PC + 32'd16);
    ready_pct = 100;
    repeat (20) step(1'b0, 32'h0);

    // Two slow requests in flight when a redirect arrives.
    addr_pct = 0;
    repeat (10) step(1'b0, 32'h0);
    lat = 3; addr_pct = 100;
    a0 = n_acc;
    repeat (2) step(1'b0, 32'h0);
    check32("inflight_accepts", 32'(n_acc - a0), 32'd2);
    step(1'b1, 32'h8000_1000);
    lat = 1;
    repeat (20) step(1'b0, 32'h0);

    // Redirect while data returns and ID would otherwise pop.
    repeat (8) step(1'b0, 32'h0);
    step(1'b1, 32'h8000_2000);
    step(1'b0, 32'h0);
    check1("post_redirect_id_valid", bus.id_valid, 1'b0);
    repeat (15) step(1'b0, 32'h0);

    // Misaligned target: one AdEL entry, then silence until an aligned redirect.
    a0 = n_acc;
    step(1'b1, 32'h8000_0002);
    repeat (10) step(1'b0, 32'h0);
    check1("adel_inst_req", bus.inst_req, 1'b0);
    check32("adel_accepts", 32'(n_acc - a0), 32'd0);
    step(1'b1, 32'h8000_0000);
    repeat (15) step(1'b0, 32'h0);

    // Asynchronous reset with three filled entries queued.
    addr_pct = 0;
    repeat (10) step(1'b0, 32'h0);
    ready_pct = 0; addr_pct = 100;
    a0 = n_acc;
    repeat (3) step(1'b0, 32'h0);
    addr_pct = 0;
    repeat (3) step(1'b0, 32'h0);
    check32("pre_reset_accepts", 32'(n_acc - a0), 32'd3);
    check1("pre_reset_id_valid", bus.id_valid, 1'b1);
    #1 resetn = 1'b0;
    #1;
    check1("async_rst_id_valid", bus.id_valid, 1'b0);
    check1("async_rst_inst_req", bus.inst_req, 1'b0);
    do_reset();
    ready_pct = 100; addr_pct = 100;
    repeat (10) step(1'b0, 32'h0);

    // Randomized traffic with occasional redirects (some misaligned).
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        lat       = $urandom_range(1, 4);
        addr_pct  = $urandom_range(30, 100);
        data_pct  = $urandom_range(30, 100);
        ready_pct = $urandom_range(20, 100);
      end
      r = $urandom;
      if (r[6:0] < 7'd4) begin
        tgt = {16'h8000, r[23:10], 2'b00};
        if (r[31:29] == 3'd0) tgt[1:0] = 2'b10;
        step(1'b1, tgt);
      end else begin
        step(1'b0, 32'h0);
      end
    end

    // Drain: everything the model still expects must reach ID.
    addr_pct = 0; data_pct = 100; ready_pct = 100; lat = 1;
    repeat (40) step(1'b0, 32'h0);
    check32("drain_leftover", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly upstream of the ID-stage decoder.
- Owns the PC and drives the SRAM-like instruction-memory interface, with up to DEPTH requests outstanding.
- Buffers returned words with their PC in an in-order queue and presents one {pc, instr, adel} per cycle to ID through a valid/ready handshake.
- Handles redirects (branch, exception, eret) by flushing the queue and discarding stale responses.

Parameters:
- DEPTH, 4: queue entries and maximum in-flight requests; power of two, at least 2.
- RESET_PC, 32'hBFC0_0000: PC after reset.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_req  out  1  fetch request valid.
- inst_addr  out  32  fetch address; equals the PC register.
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  one read word returned this cycle; responses come back in order.
- inst_rdata  in  32  returned instruction word.
- redirect_valid  in  1  flush the fetch path and restart at redirect_pc.
- redirect_pc  in  32  new fetch PC.
- id_valid  out  1  head entry is filled and presented to ID.
- id_ready  in  1  ID accepts the head entry.
- id_pc  out  32  PC of the head entry.
- id_instr  out  32  instruction word of the head entry; 0 when id_adel=1.
- id_adel  out  1  fetch address-error (AdEL) flag for the head entry.

Behaviour:
- Reset (async, resetn=0):
  - pc=RESET_PC; queue empty (rd_ptr=wr_ptr=fill_ptr=0, count=0); discard_cnt=0; state RUN.
  - Outputs: inst_req=0, id_valid=0, id_pc=0, id_instr=0, id_adel=0.
  - Reset asserted mid-transfer drops all state; responses arriving after release for pre-reset requests are the memory's responsibility and are not tracked.
- Queue entries are {pc, instr, adel, filled}.
  - Slot reserved at wr_ptr on request acceptance; filled in order at fill_ptr on inst_data_ok; popped at rd_ptr.
  - Pointers wrap modulo DEPTH. count = number of reserved entries.
- inst_req = (state==RUN) && !redirect_valid && pc[1:0]==0 && count<DEPTH. Combinational; no registered request.
- Accept (inst_req && inst_addr_ok):
  - Reserve slot {pc, filled=0}; count++; wr_ptr++; pc<=pc+4 with 32-bit wrap.
  - Latency: data may return no earlier than the following cycle.
- Response (inst_data_ok):
  - If discard_cnt>0: discard_cnt--, word dropped.
  - Otherwise: entry[fill_ptr].instr<=inst_rdata, filled<=1, fill_ptr++.
- Misaligned PC (state RUN, pc[1:0]!=0, count<DEPTH, no redirect):
  - No request issued.
  - Reserve and immediately fill {pc, instr=0, adel=1}; go to HALT.
  - HALT issues nothing until redirect.
- Output: id_valid = entry[rd_ptr].filled && count>0 && !redirect_valid; id_* driven from entry[rd_ptr].
  - Pop on id_valid && id_ready: rd_ptr++, count--.
- Redirect (redirect_valid=1), highest priority:
  - pc<=redirect_pc; state<=RUN.
  - discard_cnt <= discard_cnt + (accepted-but-unreturned requests) − (inst_data_ok this cycle && counted as old).
  - All pointers reset to 0 and count=0; no pop occurs this cycle.
  - Words returned in the redirect cycle belong to the old path and are dropped.
  - Ordering: ID raises redirect only after the branch delay slot has been popped.
- Simultaneous events:
  - Accept + pop in the same cycle: count unchanged.
  - Accept + response to the same slot cannot occur, because data is never returned in the accept cycle.
  - Pop + response in the same cycle are independent.
- Full (count==DEPTH): inst_req=0 and the PC holds.
- Empty: id_valid=0.
- discard_cnt width is clog2(DEPTH)+1; it never exceeds DEPTH.
- New-path data can only fill after discard_cnt reaches 0; this is guaranteed by in-order memory responses.

Decomposition:
- Shared CPU package (CPU_Defines) gets:
  - the RESET_PC constant `PC_RESET_VECTOR;
  - a packed struct IF_ID_Entry {pc, instr, adel};
  - a typedef enum FetchState {FETCH_RUN, FETCH_HALT}.
- The queue storage with reserve/fill/pop pointers is a natural sub-module, fetch_fifo (parameter DEPTH).
- PC, request and discard logic stay in fetch_queue.

Test Plan:
- Reset then release, memory with addr_ok=1 and 1-cycle data_ok, id_ready=1 -> inst_addr sequence BFC00000, BFC00004, BFC00008…; id_pc follows the same sequence one cycle after data_ok, with id_instr matching.
- id_ready=0 for 10 cycles -> exactly 4 requests accepted, inst_req=0 afterwards, pc=BFC00010; releasing id_ready drains the 4 entries in order, then fetch resumes.
- Memory latency 3 cycles with 2 requests in flight, redirect_valid to 80001000 -> the 2 stale words are dropped (never reach id_valid); first presented id_pc=80001000.
- Redirect in the same cycle as inst_data_ok and id_valid&&id_ready -> no pop counted, stale word dropped, count=0 next cycle.
- redirect_pc=80000002 -> no inst_req; one entry with id_adel=1, id_pc=80000002, id_instr=0; no further requests until the next redirect to 80000000, which resumes normal fetch.
- Assert resetn=0 while count=3 -> id_valid=0 and inst_req=0 immediately (async); after release, fetch restarts at BFC00000.
